// File: rtl/neopixel_strip_driver.sv
`default_nettype none
// ============================================================================
// Module   : neopixel_strip_driver
// Purpose  : NUM_PIXELS x 24-bit frame buffer streamed to a WS2812 strip in
//            GRB order, MSB first, followed by a latch period.
//            Optional build macro NEOPIX_BRIGHTNESS_EN adds a brightness input.
// Revision : 1.0 - initial release
// ============================================================================
module neopixel_strip_driver #(
   parameter int NUM_PIXELS = 8,
   parameter int T0H_CYC    = 20,
   parameter int T1H_CYC    = 40,
   parameter int BIT_CYC    = 63,
   parameter int LATCH_CYC  = 2500
) (
   input  logic                          CLOCK_50,
   input  logic                          reset,
   input  logic [$clog2(NUM_PIXELS)-1:0] pixel,
   input  logic [7:0]                    red,
   input  logic [7:0]                    green,
   input  logic [7:0]                    blue,
   input  logic                          load,
   input  logic                          go,
`ifdef NEOPIX_BRIGHTNESS_EN
   input  logic [7:0]                    brightness,
`endif
   output logic                          ready,
   output logic                          neopixel_data
);

   localparam int PIX_W     = $clog2(NUM_PIXELS);
   localparam int c_MAX_CYC = (BIT_CYC > LATCH_CYC) ? BIT_CYC : LATCH_CYC;
   localparam int TMR_W     = $clog2(c_MAX_CYC + 1);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_HIGH  = 2'd1;
   localparam logic [1:0] c_LOW   = 2'd2;
   localparam logic [1:0] c_LATCH = 2'd3;

   localparam logic [TMR_W-1:0] c_T0H_END   = TMR_W'(T0H_CYC - 1);
   localparam logic [TMR_W-1:0] c_T1H_END   = TMR_W'(T1H_CYC - 1);
   localparam logic [TMR_W-1:0] c_BIT_END   = TMR_W'(BIT_CYC - 1);
   localparam logic [TMR_W-1:0] c_LATCH_END = TMR_W'(LATCH_CYC - 1);
   localparam logic [PIX_W-1:0] c_LAST_PIX  = PIX_W'(NUM_PIXELS - 1);
   localparam logic [4:0]       c_TOP_BIT   = 5'd23;

   logic [23:0]      r_buf [NUM_PIXELS];
   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [TMR_W-1:0] r_tmr;
   logic [PIX_W-1:0] r_pix_cnt;
   logic [4:0]       r_bit_cnt;
   logic             r_data;
   logic             r_ready;

   logic             w_in_range;
   logic [23:0]      w_grb;
   logic [23:0]      w_tx_grb;
   logic             w_tx_bit;
   logic [TMR_W-1:0] w_high_end;
   logic             w_bit_end;
   logic             w_last_bit;
   logic             w_pix_adv;

   // A power-of-two strip cannot be addressed out of range.
   generate
      if (NUM_PIXELS == (1 << PIX_W)) begin : g_full_range
         assign w_in_range = 1'b1;
      end else begin : g_partial_range
         assign w_in_range = (int'(pixel) < NUM_PIXELS);
      end
   endgenerate

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         for (int i = 0; i < NUM_PIXELS; i++) begin
            r_buf[i] <= '0;
         end
      end else if (r_state == c_IDLE && load && w_in_range) begin
         r_buf[pixel] <= {green, red, blue};
      end
   end

   assign w_grb      = r_buf[r_pix_cnt];
   assign w_tx_bit   = w_tx_grb[r_bit_cnt];
   assign w_high_end = w_tx_bit ? c_T1H_END : c_T0H_END;
   assign w_bit_end  = (r_tmr == c_BIT_END);
   assign w_last_bit = (r_bit_cnt == 5'd0) && (r_pix_cnt == c_LAST_PIX);
   assign w_pix_adv  = (r_state == c_LOW) && w_bit_end && (r_bit_cnt == 5'd0)
                       && (r_pix_cnt != c_LAST_PIX);

`ifdef NEOPIX_BRIGHTNESS_EN
   logic [7:0] r_bright;

   function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
      logic [15:0] p;
      p = {8'd0, c} * ({8'd0, b} + 16'd1);
      return 8'(p >> 8);
   endfunction

   // Brightness is frozen for the duration of each pixel.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_bright <= 8'd0;
      end else if (r_state == c_IDLE || w_pix_adv) begin
         r_bright <= brightness;
      end
   end

   assign w_tx_grb = {scale(w_grb[23:16], r_bright),
                      scale(w_grb[15:8],  r_bright),
                      scale(w_grb[7:0],   r_bright)};
`else
   assign w_tx_grb = w_grb;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (go) w_state_nxt = c_HIGH;
         c_HIGH:  if (r_tmr == w_high_end) w_state_nxt = c_LOW;
         c_LOW:   if (w_bit_end) w_state_nxt = w_last_bit ? c_LATCH : c_HIGH;
         c_LATCH: if (r_tmr == c_LATCH_END) w_state_nxt = c_IDLE;
         default: w_state_nxt = c_IDLE;
      endcase
   end

   // The bit timer runs across HIGH and LOW so one compare ends the bit.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state   <= c_IDLE;
         r_tmr     <= '0;
         r_pix_cnt <= '0;
         r_bit_cnt <= c_TOP_BIT;
         r_data    <= 1'b0;
         r_ready   <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_data  <= (w_state_nxt == c_HIGH);
         r_ready <= (w_state_nxt == c_IDLE);
         case (r_state)
            c_IDLE: begin
               r_tmr     <= '0;
               r_pix_cnt <= '0;
               r_bit_cnt <= c_TOP_BIT;
            end
            c_LOW: begin
               if (w_bit_end) begin
                  r_tmr <= '0;
                  if (r_bit_cnt != 5'd0) begin
                     r_bit_cnt <= r_bit_cnt - 5'd1;
                  end else if (r_pix_cnt != c_LAST_PIX) begin
                     r_pix_cnt <= r_pix_cnt + PIX_W'(1);
                     r_bit_cnt <= c_TOP_BIT;
                  end
               end else begin
                  r_tmr <= r_tmr + TMR_W'(1);
               end
            end
            default: r_tmr <= r_tmr + TMR_W'(1);
         endcase
      end
   end

   assign ready         = r_ready;
   assign neopixel_data = r_data;

endmodule
`default_nettype wire
